adc_ctrl_muestreo: RTL



---
 rtl/adc_ctrl_muestreo_if.sv | 21 ++
 rtl/adc_ctrl_muestreo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/adc_ctrl_muestreo_if.sv
// Pins of the serial ADC plus the result valid/ack handshake toward the consumer.
// master = the sampling controller, slave = ADC pins and result consumer.
interface adc_ctrl_muestreo_if;
  logic        adc_cs;
  logic        adc_sclk;
  logic        SDATA;
  logic [11:0] sample;
  logic [11:0] sample_twos;
  logic        sample_valid;
  logic        sample_ack;

  modport master (
    output adc_cs, adc_sclk, sample, sample_twos, sample_valid,
    input  SDATA, sample_ack
  );

  modport slave (
    input  adc_cs, adc_sclk, sample, sample_twos, sample_valid,
    output SDATA, sample_ack
  );
endinterface

// File: rtl/adc_ctrl_muestreo.sv
// Periodic single-frame serial ADC sampler (4 leading zeros + 12 data bits, MSB first), fully in clk.
// Optional sticky overwrite flag: define ADC_OVERRUN_EN. Requires CLK_DIV >= 1 and QUIET_CYCLES >= 1.
module adc_ctrl_muestreo #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int QUIET_CYCLES  = 8
) (
  input  logic                clk,
  input  logic                reset,
  adc_ctrl_muestreo_if.master bus,
  input  logic                enable,
`ifdef ADC_OVERRUN_EN
  input  logic                overrun_clr,
  output logic                overrun,
`endif
  output logic                busy
);

  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int QW    = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CONV  = 2'd1;
  localparam logic [1:0] S_QUIET = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic [PER_W-1:0] period_cnt_q, period_cnt_d;
  logic [DIV_W-1:0] div_cnt_q,    div_cnt_d;
  logic [4:0]       bit_cnt_q,    bit_cnt_d;
  logic [QW-1:0]    quiet_cnt_q,  quiet_cnt_d;
  logic [11:0]      shift_q,      shift_d;
  logic             cs_q,         cs_d;
  logic             sclk_q,       sclk_d;
  logic [11:0]      sample_q,     sample_d;
  logic             valid_q,      valid_d;
  logic             start;
  logic             load;
`ifdef ADC_OVERRUN_EN
  logic             overrun_q,    overrun_d;
`endif

  assign start = enable && (period_cnt_q == PER_LAST);

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path can leave one unassigned and infer a latch.
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    quiet_cnt_d  = quiet_cnt_q;
    shift_d      = shift_q;
    cs_d         = cs_q;
    sclk_d       = sclk_q;
    sample_d     = sample_q;
    valid_d      = valid_q;
    load         = 1'b0;

    if (!enable || period_cnt_q == PER_LAST) period_cnt_d = '0;
    else                                     period_cnt_d = period_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        cs_d   = 1'b1;
        sclk_d = 1'b1;
        if (start) begin
          state_d   = S_CONV;
          cs_d      = 1'b0;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
        end
      end
      S_CONV: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // Only the low 12 bits are kept; the four leading zeros fall off the top.
            shift_d   = {shift_q[10:0], bus.SDATA};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (bit_cnt_q == 5'd16) begin
            state_d     = S_QUIET;
            cs_d        = 1'b1;
            sclk_d      = 1'b1;
            quiet_cnt_d = '0;
            load        = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_QUIET: begin
        cs_d   = 1'b1;
        sclk_d = 1'b1;
        if (quiet_cnt_q == QUIET_LAST) begin
          state_d     = S_IDLE;
          quiet_cnt_d = '0;
        end else begin
          quiet_cnt_d = quiet_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b1;
      end
    endcase

    // A fresh result beats a coincident ack: latest data stays flagged as unread.
    if (load) begin
      sample_d = shift_q;
      valid_d  = 1'b1;
    end else if (valid_q && bus.sample_ack) begin
      valid_d = 1'b0;
    end
  end

`ifdef ADC_OVERRUN_EN
  always_comb begin
    overrun_d = overrun_q;
    if (load && valid_q && !bus.sample_ack) overrun_d = 1'b1;
    else if (overrun_clr)                   overrun_d = 1'b0;
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      period_cnt_q <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      quiet_cnt_q  <= '0;
      shift_q      <= '0;
      cs_q         <= 1'b1;
      sclk_q       <= 1'b1;
      sample_q     <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      quiet_cnt_q  <= quiet_cnt_d;
      shift_q      <= shift_d;
      cs_q         <= cs_d;
      sclk_q       <= sclk_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
    end
  end

`ifdef ADC_OVERRUN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end
  assign overrun = overrun_q;
`endif

  assign bus.adc_cs       = cs_q;
  assign bus.adc_sclk     = sclk_q;
  assign bus.sample       = sample_q;
  assign bus.sample_twos  = {~sample_q[11], sample_q[10:0]};
  assign bus.sample_valid = valid_q;
  assign busy             = (state_q != S_IDLE);

endmodule
